// File: rtl/stage_mem_pkg.sv
// Shared constants for the memory stage: datapath widths, funct3 size
// encodings, FSM state type and the size-to-width decode helpers.
package stage_mem_pkg;

  localparam int DATA_WID = 32;
  localparam int REGS_WID = 5;
  localparam int STRB_WID = DATA_WID / 8;

  // funct3 encodings of the load/store access size
  typedef enum logic [2:0] {
    MS_LB  = 3'b000,
    MS_LH  = 3'b001,
    MS_LW  = 3'b010,
    MS_LBU = 3'b100,
    MS_LHU = 3'b101
  } mem_size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    W_BYTE = 2'd0,
    W_HALF = 2'd1,
    W_WORD = 2'd2
  } width_e;

  // Access width from funct3; any code outside the known set is a word.
  function automatic width_e size_width(input logic [2:0] sz);
    case (sz)
      MS_LB, MS_LBU: return W_BYTE;
      MS_LH, MS_LHU: return W_HALF;
      default:       return W_WORD;
    endcase
  endfunction

  // Only lb and lh sign-extend the loaded value.
  function automatic logic size_signed(input logic [2:0] sz);
    return (sz == MS_LB) || (sz == MS_LH);
  endfunction

endpackage

// File: rtl/stage_mem_if.sv
// Data-memory bus between the memory stage (master) and memory (slave).
interface stage_mem_if;
  import stage_mem_pkg::*;

  logic                bus_req;
  logic                bus_we;
  logic [DATA_WID-1:0] bus_addr;
  logic [DATA_WID-1:0] bus_wdata;
  logic [STRB_WID-1:0] bus_wstrb;
  logic [DATA_WID-1:0] bus_rdata;
  logic                bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
    output bus_rdata, bus_ack
  );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering for stores, alignment check, and load extraction with
// sign/zero extension. Purely combinational.
module lsu_align
  import stage_mem_pkg::*;
(
  input  logic [1:0]          st_off,
  input  logic [2:0]          st_size,
  input  logic [DATA_WID-1:0] st_data,
  output logic [STRB_WID-1:0] st_strb,
  output logic [DATA_WID-1:0] st_wdata,
  output logic                misaligned,
  input  logic [1:0]          ld_off,
  input  logic [2:0]          ld_size,
  input  logic [DATA_WID-1:0] ld_rdata,
  output logic [DATA_WID-1:0] ld_data
);

  logic        [DATA_WID-1:0] shifted;
  logic signed [7:0]          ld_byte;
  logic signed [15:0]         ld_half;
  logic signed [DATA_WID-1:0] sext_byte;
  logic signed [DATA_WID-1:0] sext_half;

  // Store side: strobes, lane replication and alignment fault detection
  always_comb begin
    st_strb    = '0;
    st_wdata   = st_data;
    misaligned = 1'b0;
    case (size_width(st_size))
      W_BYTE: begin
        st_strb  = STRB_WID'(1) << st_off;
        st_wdata = {STRB_WID{st_data[7:0]}};
      end
      W_HALF: begin
        st_strb    = STRB_WID'(3) << {st_off[1], 1'b0};
        st_wdata   = {(STRB_WID/2){st_data[15:0]}};
        misaligned = st_off[0];
      end
      default: begin
        st_strb    = '1;
        misaligned = |st_off;
      end
    endcase
  end

  // Load side: move the addressed lane to bit 0, then extend by size
  always_comb begin
    shifted   = ld_rdata >> {ld_off, 3'b000};
    ld_byte   = shifted[7:0];
    ld_half   = shifted[15:0];
    sext_byte = DATA_WID'(ld_byte);
    sext_half = DATA_WID'(ld_half);
    case (size_width(ld_size))
      W_BYTE:  ld_data = size_signed(ld_size) ? sext_byte : DATA_WID'(shifted[7:0]);
      W_HALF:  ld_data = size_signed(ld_size) ? sext_half : DATA_WID'(shifted[15:0]);
      // aligned words always have a zero offset, so the shift is a pass-through
      default: ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/stage_mem.sv
// Pipeline memory stage: issues one data-bus access per load/store, stalls
// upstream while the access is outstanding, and owns the MEM/WB register.
module stage_mem
  import stage_mem_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [2:0]          mem_size,
  input  logic [DATA_WID-1:0] addr,
  input  logic [DATA_WID-1:0] store_data,
  input  logic [REGS_WID-1:0] rd,
  input  logic                reg_write,
  stage_mem_if.master         bus,
  output logic                stall,
  output logic                misalign,
  output logic                wb_valid,
  output logic                wb_reg_write,
  output logic [REGS_WID-1:0] wb_rd,
  output logic [DATA_WID-1:0] wb_data
);

  state_e state_q, state_d;

  logic                is_mem;
  logic                mis;
  logic                take_op;
  logic                take_fault;
  logic                alu_pass;
  logic                done;
  logic                bus_req_c;

  logic [STRB_WID-1:0] st_strb;
  logic [DATA_WID-1:0] st_wdata;
  logic [DATA_WID-1:0] ld_data;

  // Request latched at acceptance; held stable for the whole bus access
  logic                we_p1;
  logic [DATA_WID-1:0] addr_p1;
  logic [DATA_WID-1:0] wdata_p1;
  logic [STRB_WID-1:0] strb_p1;
  logic [2:0]          size_p1;
  logic [REGS_WID-1:0] rd_p1;
  logic                regw_p1;

  assign is_mem = in_valid & (mem_read | mem_write);

  lsu_align u_align (
    .st_off     (addr[1:0]),
    .st_size    (mem_size),
    .st_data    (store_data),
    .st_strb    (st_strb),
    .st_wdata   (st_wdata),
    .misaligned (mis),
    .ld_off     (addr_p1[1:0]),
    .ld_size    (size_p1),
    .ld_rdata   (bus.bus_rdata),
    .ld_data    (ld_data)
  );

  assign bus.bus_req   = bus_req_c;
  assign bus.bus_we    = we_p1;
  assign bus.bus_addr  = {addr_p1[DATA_WID-1:2], 2'b00};
  assign bus.bus_wdata = wdata_p1;
  assign bus.bus_wstrb = strb_p1;

  // FSM state register; async reset drops any outstanding access at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state and combinational handshake outputs (forced quiet in reset)
  always_comb begin
    state_d    = state_q;
    stall      = 1'b0;
    misalign   = 1'b0;
    bus_req_c  = 1'b0;
    take_op    = 1'b0;
    take_fault = 1'b0;
    alu_pass   = 1'b0;
    done       = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
          if (is_mem && mis) begin
            misalign   = 1'b1;
            take_fault = 1'b1;
          end else if (is_mem) begin
            stall   = 1'b1;
            take_op = 1'b1;
            state_d = ST_BUSY;
          end else if (in_valid) begin
            alu_pass = 1'b1;
          end
        end
        ST_BUSY: begin
          bus_req_c = 1'b1;
          stall     = ~bus.bus_ack;
          if (bus.bus_ack) begin
            done    = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // ---- EX/MEM -> bus request boundary ----
  // Capture the steered request when an aligned access is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_p1    <= 1'b0;
      addr_p1  <= '0;
      wdata_p1 <= '0;
      strb_p1  <= '0;
      size_p1  <= '0;
      rd_p1    <= '0;
      regw_p1  <= 1'b0;
    end else if (take_op) begin
      we_p1    <= mem_write;
      addr_p1  <= addr;
      wdata_p1 <= st_wdata;
      strb_p1  <= st_strb;
      size_p1  <= mem_size;
      rd_p1    <= rd;
      regw_p1  <= reg_write;
    end
  end

  // ---- MEM/WB boundary ----
  // Load the writeback slot from a completed access, a fault or an ALU pass
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
    end else if (done) begin
      wb_valid     <= 1'b1;
      wb_reg_write <= regw_p1 & ~we_p1;
      wb_rd        <= rd_p1;
      wb_data      <= we_p1 ? addr_p1 : ld_data;
    end else if (take_fault) begin
      wb_valid     <= 1'b1;
      wb_reg_write <= 1'b0;
      wb_rd        <= rd;
      wb_data      <= addr;
    end else if (alu_pass) begin
      wb_valid     <= 1'b1;
      wb_reg_write <= reg_write;
      wb_rd        <= rd;
      wb_data      <= addr;
    end else begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stage_mem.sv
// Testbench for stage_mem: instruction-level reference model, randomized
// operation stream with random bus latency, directed scenarios and reset.
module tb_stage_mem;
  import stage_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, mem_read, mem_write, reg_write;
  logic [2:0]  mem_size;
  logic [31:0] addr, store_data;
  logic [4:0]  rd;
  logic        stall, misalign, wb_valid, wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  stage_mem_if bus ();

  stage_mem dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_size     (mem_size),
    .addr         (addr),
    .store_data   (store_data),
    .rd           (rd),
    .reg_write    (reg_write),
    .bus          (bus),
    .stall        (stall),
    .misalign     (misalign),
    .wb_valid     (wb_valid),
    .wb_reg_write (wb_reg_write),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;
  int stall_seen = 0;
  logic chk_en = 1'b0;

  // expected values for the current cycle
  logic        exp_stall, exp_mis, exp_req, exp_we;
  logic [31:0] exp_baddr, exp_wdata;
  logic [3:0]  exp_wstrb;
  logic        exp_wb_valid, exp_wb_rw, exp_wb_chkd;
  logic [4:0]  exp_wb_rd;
  logic [31:0] exp_wb_data;
  // writeback the model expects after the coming edge
  logic        pend_valid, pend_rw, pend_chkd;
  logic [4:0]  pend_rd;
  logic [31:0] pend_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [2:0] sz);
    case (sz)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic logic m_mis(input logic [2:0] sz, input logic [1:0] off);
    return (int'(off) % nbytes(sz)) != 0;
  endfunction

  function automatic logic [3:0] m_strb(input logic [2:0] sz, input logic [1:0] off);
    return 4'(((1 << nbytes(sz)) - 1) << off);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] sz, input logic [31:0] d);
    if (nbytes(sz) == 1) return 32'(d[7:0]) * 32'h01010101;
    if (nbytes(sz) == 2) return 32'(d[15:0]) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] sz, input logic [1:0] off,
                                         input logic [31:0] rdat);
    logic [31:0] v;
    logic        sgn;
    sgn = (sz == 3'b000) || (sz == 3'b001);
    v = rdat >> (32'd8 * 32'(off));
    if (nbytes(sz) == 1) begin
      v = v & 32'hFF;
      if (sgn && v >= 32'd128) v = v - 32'd256;
    end else if (nbytes(sz) == 2) begin
      v = v & 32'hFFFF;
      if (sgn && v >= 32'd32768) v = v - 32'd65536;
    end
    return v;
  endfunction

  // Advance one cycle; the writeback predicted for that edge becomes current
  task automatic tick();
    @(posedge clk);
    #1;
    exp_wb_valid = pend_valid;
    exp_wb_rw    = pend_rw;
    exp_wb_rd    = pend_rd;
    exp_wb_data  = pend_data;
    exp_wb_chkd  = pend_chkd;
  endtask

  // Present one EX/MEM slot and follow it to completion; returns one
  // cycle into the ack cycle (memory op) or into the presentation cycle.
  task automatic run_op(input logic v, input logic r, input logic w, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rdd,
                        input logic rw, input int lat, input logic [31:0] rdat);
    logic mem, mis;
    mem = v && (r || w);
    mis = m_mis(sz, a[1:0]);
    tick();
    in_valid = v; mem_read = r; mem_write = w; mem_size = sz;
    addr = a; store_data = sd; rd = rdd; reg_write = rw;
    bus.bus_ack   = 1'($urandom_range(0, 1));
    bus.bus_rdata = $urandom;
    exp_req   = 1'b0;
    exp_stall = mem && !mis;
    exp_mis   = mem && mis;
    if (!mem) begin
      pend_valid = v;
      pend_rw    = v && rw;
      if (v) begin
        pend_rd = rdd; pend_data = a; pend_chkd = 1'b1;
      end
    end else if (mis) begin
      pend_valid = 1'b1; pend_rw = 1'b0; pend_rd = rdd; pend_chkd = 1'b0;
    end else begin
      pend_valid = 1'b0; pend_rw = 1'b0;
      for (int i = 0; i <= lat; i++) begin
        tick();
        exp_req   = 1'b1;
        exp_mis   = 1'b0;
        exp_we    = w;
        exp_baddr = {a[31:2], 2'b00};
        exp_wstrb = m_strb(sz, a[1:0]);
        exp_wdata = m_wdata(sz, sd);
        exp_stall = (i != lat);
        bus.bus_ack   = (i == lat);
        bus.bus_rdata = (i == lat) ? rdat : $urandom;
        if (i == lat) begin
          pend_valid = 1'b1;
          pend_rw    = rw && !w;
          pend_rd    = rdd;
          pend_data  = m_load(sz, a[1:0], rdat);
          pend_chkd  = !w;
        end
      end
    end
  endtask

  task automatic idle_op();
    run_op(1'b0, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 5'd0, 1'b0, 0, 32'h0);
  endtask

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (stall === 1'b1) stall_seen++;
      if (chk_en) begin
        chk("stall", 32'(stall), 32'(exp_stall));
        chk("misalign", 32'(misalign), 32'(exp_mis));
        chk("bus_req", 32'(bus.bus_req), 32'(exp_req));
        if (exp_req) begin
          chk("bus_we", 32'(bus.bus_we), 32'(exp_we));
          chk("bus_addr", bus.bus_addr, exp_baddr);
          if (exp_we) begin
            chk("bus_wstrb", 32'(bus.bus_wstrb), 32'(exp_wstrb));
            chk("bus_wdata", bus.bus_wdata, exp_wdata);
          end
        end
        chk("wb_valid", 32'(wb_valid), 32'(exp_wb_valid));
        chk("wb_reg_write", 32'(wb_reg_write), 32'(exp_wb_rw));
        if (exp_wb_valid) begin
          chk("wb_rd", 32'(wb_rd), 32'(exp_wb_rd));
          if (exp_wb_chkd) chk("wb_data", wb_data, exp_wb_data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic model_quiet();
    exp_stall = 1'b0; exp_mis = 1'b0; exp_req = 1'b0; exp_we = 1'b0;
    exp_baddr = '0; exp_wdata = '0; exp_wstrb = '0;
    exp_wb_valid = 1'b0; exp_wb_rw = 1'b0; exp_wb_rd = '0; exp_wb_data = '0; exp_wb_chkd = 1'b0;
    pend_valid = 1'b0; pend_rw = 1'b0; pend_rd = '0; pend_data = '0; pend_chkd = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    model_quiet();
    // reset with a load presented: everything must stay quiet
    rst = 1'b1;
    in_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_size = 3'b010;
    addr = 32'h100; store_data = '0; rd = 5'd1; reg_write = 1'b1;
    bus.bus_ack = 1'b0; bus.bus_rdata = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    chk("rst_bus_req", 32'(bus.bus_req), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_reg_write", 32'(wb_reg_write), 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    in_valid = 1'b0; mem_read = 1'b0;
    rst = 1'b0;
    chk_en = 1'b1;

    // lw 0x100, ack after three waiting cycles
    base = stall_seen;
    run_op(1'b1, 1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5'd3, 1'b1, 3, 32'hDEADBEEF);
    idle_op();
    #1;
    chk("lw_wb_data", wb_data, 32'hDEADBEEF);
    chk("lw_wb_reg_write", 32'(wb_reg_write), 32'd1);
    chk("lw_stall_cycles", 32'(stall_seen - base), 32'd4);

    // lb / lbu from 0x103
    run_op(1'b1, 1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 5'd4, 1'b1, 0, 32'h80FF0000);
    idle_op();
    #1;
    chk("lb_wb_data", wb_data, 32'hFFFFFF80);
    run_op(1'b1, 1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 5'd4, 1'b1, 1, 32'h80FF0000);
    idle_op();
    #1;
    chk("lbu_wb_data", wb_data, 32'h00000080);

    // sh 0x1234ABCD to 0x202
    run_op(1'b1, 1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 5'd9, 1'b1, 1, 32'h0);
    #1;
    chk("sh_bus_addr", bus.bus_addr, 32'h200);
    chk("sh_bus_wstrb", 32'(bus.bus_wstrb), 32'hC);
    chk("sh_bus_wdata", bus.bus_wdata, 32'hABCDABCD);
    idle_op();
    #1;
    chk("sh_wb_valid", 32'(wb_valid), 32'd1);
    chk("sh_wb_reg_write", 32'(wb_reg_write), 32'd0);

    // misaligned lw from 0x101
    run_op(1'b1, 1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 5'd2, 1'b1, 0, 32'h0);
    #1;
    chk("mis_pulse", 32'(misalign), 32'd1);
    chk("mis_no_req", 32'(bus.bus_req), 32'd0);
    idle_op();
    #1;
    chk("mis_pulse_end", 32'(misalign), 32'd0);
    chk("mis_wb_valid", 32'(wb_valid), 32'd1);
    chk("mis_wb_reg_write", 32'(wb_reg_write), 32'd0);

    // ALU pass-through addr=5 rd=7
    base = stall_seen;
    run_op(1'b1, 1'b0, 1'b0, 3'b010, 32'h5, 32'h0, 5'd7, 1'b1, 0, 32'h0);
    idle_op();
    #1;
    chk("alu_wb_data", wb_data, 32'h5);
    chk("alu_wb_rd", 32'(wb_rd), 32'd7);
    chk("alu_no_stall", 32'(stall_seen - base), 32'd0);

    // randomized stream, including back-to-back ops
    for (int k = 0; k < 300; k++) begin
      logic v, r, w, rw;
      logic [2:0] sz;
      logic [31:0] a, sd, rdat;
      logic [4:0] rdd;
      int lat;
      v = ($urandom_range(0, 7) != 0);
      case ($urandom_range(0, 3))
        0: begin r = 1'b0; w = 1'b0; end
        1: begin r = 1'b1; w = 1'b0; end
        2: begin r = 1'b0; w = 1'b1; end
        default: begin r = 1'b1; w = ($urandom_range(0, 2) == 0); end
      endcase
      sz   = 3'($urandom_range(0, 7));
      a    = $urandom;
      sd   = $urandom;
      rdat = $urandom;
      rdd  = 5'($urandom_range(0, 31));
      rw   = 1'($urandom_range(0, 1));
      lat  = $urandom_range(0, 3);
      run_op(v, r, w, sz, a, sd, rdd, rw, lat, rdat);
    end

    // reset during an outstanding access, then a stray ack afterwards
    tick();
    in_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_size = 3'b010;
    addr = 32'h300; rd = 5'd5; reg_write = 1'b1; bus.bus_ack = 1'b0;
    exp_stall = 1'b1; exp_mis = 1'b0; exp_req = 1'b0;
    pend_valid = 1'b0; pend_rw = 1'b0;
    tick();
    exp_req = 1'b1; exp_we = 1'b0; exp_baddr = 32'h300; exp_stall = 1'b1;
    @(posedge clk);
    #1;
    chk_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("rstbusy_bus_req", 32'(bus.bus_req), 32'd0);
    chk("rstbusy_stall", 32'(stall), 32'd0);
    chk("rstbusy_wb_valid", 32'(wb_valid), 32'd0);
    in_valid = 1'b0; mem_read = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    bus.bus_ack = 1'b1;
    bus.bus_rdata = 32'hCAFEF00D;
    #1;
    chk("late_ack_bus_req", 32'(bus.bus_req), 32'd0);
    chk("late_ack_stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    bus.bus_ack = 1'b0;
    #1;
    chk("late_ack_wb_valid", 32'(wb_valid), 32'd0);
    chk("late_ack_idle", 32'(bus.bus_req), 32'd0);
    model_quiet();
    chk_en = 1'b1;

    // recovery: a fresh load after the reset
    run_op(1'b1, 1'b1, 1'b0, 3'b101, 32'h402, 32'h0, 5'd6, 1'b1, 2, 32'h8001_7FFF);
    idle_op();
    #1;
    chk("lhu_after_rst", wb_data, 32'h00008001);
    idle_op();

    @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
